// File: rtl/ram_port_b_arbiter_pkg.sv
// Shared types for the RAM port B arbiter: owner encoding, FSM states, read tag.
package ram_port_b_arbiter_pkg;

    typedef enum logic {
        CORE = 1'b0,
        PIX  = 1'b1
    } owner_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OWN_CORE = 2'd1,
        OWN_PIX  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic   vld;
        owner_t owner;
    } rd_tag_t;

    localparam int DEF_RD_LAT   = 1;
    localparam int DEF_MAX_LOCK = 4;

    function automatic arb_state_t own_state(owner_t o);
        return (o == PIX) ? OWN_PIX : OWN_CORE;
    endfunction

endpackage

// File: rtl/ram_port_b_arbiter_rd_tag_pipe.sv
// Shift register of {valid, owner} tags that tracks reads in flight through the RAM.
// One entry enters per cycle; the last stage lines up with the returned ram_rdata.
module rd_tag_pipe
    import ram_port_b_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk_i,
    input  logic   clr_n_i,
    input  logic   in_vld_i,
    input  owner_t in_owner_i,
    output logic   out_vld_o,
    output owner_t out_owner_o
);

    rd_tag_t tag_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (!clr_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '{vld: 1'b0, owner: CORE};
            end
        end else begin
            tag_q[0] <= '{vld: in_vld_i, owner: in_owner_i};
            for (int i = 1; i < DEPTH; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign out_vld_o   = tag_q[DEPTH-1].vld;
    assign out_owner_o = tag_q[DEPTH-1].owner;

endmodule

// File: rtl/ram_port_b_arbiter.sv
// Round-robin arbiter for RAM port B between the soft core and the pixel writer,
// with a bounded lock for atomic read-modify-write and read-data return routing.
module ram_port_b_arbiter
    import ram_port_b_arbiter_pkg::*;
#(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int RD_LAT   = DEF_RD_LAT,
    parameter int MAX_LOCK = DEF_MAX_LOCK
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          core_req,
    input  logic          core_we,
    input  logic          core_lock,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,

    input  logic          pix_req,
    input  logic          pix_we,
    input  logic          pix_lock,
    input  logic [AW-1:0] pix_addr,
    input  logic [DW-1:0] pix_wdata,
    output logic          pix_gnt,
    output logic          pix_rvalid,
    output logic [DW-1:0] pix_rdata,

    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata
);

    arb_state_t    state_q, state_d;
    logic [3:0]    lock_cnt_q, lock_cnt_d;
    owner_t        last_owner_q, last_owner_d;

    logic [AW-1:0] ram_addr_q;
    logic [DW-1:0] ram_wdata_q;
    logic          ram_we_q;
    logic [DW-1:0] core_rdata_q, pix_rdata_q;

    logic          core_elig, pix_elig;
    logic          gnt_any, gnt_lock, gnt_we;
    owner_t        gnt_owner;
    logic [3:0]    cnt_inc;

    logic          tag_vld;
    owner_t        tag_owner;

    // State register plus the registered port B access.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            lock_cnt_q   <= 4'd0;
            last_owner_q <= PIX;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_we_q     <= 1'b0;
            core_rdata_q <= '0;
            pix_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            lock_cnt_q   <= lock_cnt_d;
            last_owner_q <= last_owner_d;
            if (gnt_any) begin
                ram_addr_q  <= pix_gnt ? pix_addr  : core_addr;
                ram_wdata_q <= pix_gnt ? pix_wdata : core_wdata;
                ram_we_q    <= gnt_we;
            end else begin
                ram_we_q    <= 1'b0;
            end
            if (core_rvalid) core_rdata_q <= ram_rdata;
            if (pix_rvalid)  pix_rdata_q  <= ram_rdata;
        end
    end

    // Grant decode: a locked owner shuts out the other requester even when idle.
    always_comb begin
        core_elig = 1'b0;
        pix_elig  = 1'b0;
        case (state_q)
            IDLE: begin
                core_elig = core_req;
                pix_elig  = pix_req;
            end
            OWN_CORE: core_elig = core_req;
            OWN_PIX:  pix_elig  = pix_req;
            default: ;
        endcase
        core_gnt = 1'b0;
        pix_gnt  = 1'b0;
        if (rst) begin
            if (core_elig && pix_elig) begin
                core_gnt = (last_owner_q == PIX);
                pix_gnt  = (last_owner_q == CORE);
            end else begin
                core_gnt = core_elig;
                pix_gnt  = pix_elig;
            end
        end
    end

    always_comb begin
        gnt_any      = core_gnt | pix_gnt;
        gnt_owner    = pix_gnt ? PIX : CORE;
        gnt_lock     = pix_gnt ? pix_lock : core_lock;
        gnt_we       = pix_gnt ? pix_we : core_we;
        cnt_inc      = lock_cnt_q + 4'd1;
        state_d      = state_q;
        lock_cnt_d   = lock_cnt_q;
        last_owner_d = last_owner_q;
        if (gnt_any) begin
            last_owner_d = gnt_owner;
            // The grant that reaches MAX_LOCK is the last one the owner keeps.
            if (gnt_lock && (cnt_inc < 4'(MAX_LOCK))) begin
                state_d    = own_state(gnt_owner);
                lock_cnt_d = cnt_inc;
            end else begin
                state_d    = IDLE;
                lock_cnt_d = 4'd0;
            end
        end
    end

    rd_tag_pipe #(
        .DEPTH (RD_LAT + 1)
    ) u_rd_tag_pipe (
        .clk_i       (clk),
        .clr_n_i     (rst),
        .in_vld_i    (gnt_any & ~gnt_we),
        .in_owner_i  (gnt_owner),
        .out_vld_o   (tag_vld),
        .out_owner_o (tag_owner)
    );

    always_comb begin
        core_rvalid = rst & tag_vld & (tag_owner == CORE);
        pix_rvalid  = rst & tag_vld & (tag_owner == PIX);
        // Bypass so rdata is valid in the same cycle as its rvalid pulse.
        core_rdata  = core_rvalid ? ram_rdata : core_rdata_q;
        pix_rdata   = pix_rvalid  ? ram_rdata : pix_rdata_q;
    end

    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;

endmodule

// File: tb/tb_ram_port_b_arbiter.sv
// Self-checking bench for ram_port_b_arbiter with a behavioural port B RAM (RD_LAT = 1).
module tb_ram_port_b_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we, core_lock;
    logic [15:0] core_addr, core_wdata;
    logic        core_gnt, core_rvalid;
    logic [15:0] core_rdata;
    logic        pix_req, pix_we, pix_lock;
    logic [15:0] pix_addr, pix_wdata;
    logic        pix_gnt, pix_rvalid;
    logic [15:0] pix_rdata;
    logic [15:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_we;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        core_q[$];
    exp_t        pix_q[$];
    logic [15:0] mem[int];
    logic [15:0] shadow[int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_port_b_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_lock  (core_lock),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_gnt   (core_gnt),
        .core_rvalid(core_rvalid),
        .core_rdata (core_rdata),
        .pix_req    (pix_req),
        .pix_we     (pix_we),
        .pix_lock   (pix_lock),
        .pix_addr   (pix_addr),
        .pix_wdata  (pix_wdata),
        .pix_gnt    (pix_gnt),
        .pix_rvalid (pix_rvalid),
        .pix_rdata  (pix_rdata),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_rdata  (ram_rdata)
    );

    function automatic logic [15:0] init_val(logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    // Port B RAM: one cycle from registered address to read data.
    always @(posedge clk) begin
        if (ram_we) mem[int'(ram_addr)] = ram_wdata;
        ram_rdata <= mem.exists(int'(ram_addr)) ? mem[int'(ram_addr)] : init_val(ram_addr);
    end

    function automatic logic [15:0] shadow_rd(logic [15:0] a);
        return shadow.exists(int'(a)) ? shadow[int'(a)] : init_val(a);
    endfunction

    // Scoreboard: compare returned reads first, then record this cycle's grants.
    always @(negedge clk) begin
        exp_t e;
        if (core_rvalid) begin
            tests++;
            if (core_q.size() == 0) begin
                fails++;
                $display("FAIL core_rvalid_unexpected: rdata %h with no read outstanding", core_rdata);
            end else begin
                e = core_q.pop_front();
                if (core_rdata !== e.data || cyc != e.due) begin
                    fails++;
                    $display("FAIL core_rdata: got %h at cycle %0d, expected %h at cycle %0d",
                             core_rdata, cyc, e.data, e.due);
                end
            end
        end
        if (pix_rvalid) begin
            tests++;
            if (pix_q.size() == 0) begin
                fails++;
                $display("FAIL pix_rvalid_unexpected: rdata %h with no read outstanding", pix_rdata);
            end else begin
                e = pix_q.pop_front();
                if (pix_rdata !== e.data || cyc != e.due) begin
                    fails++;
                    $display("FAIL pix_rdata: got %h at cycle %0d, expected %h at cycle %0d",
                             pix_rdata, cyc, e.data, e.due);
                end
            end
        end
        if (core_gnt) begin
            if (core_we) shadow[int'(core_addr)] = core_wdata;
            else core_q.push_back('{data: shadow_rd(core_addr), due: cyc + 2});
        end
        if (pix_gnt) begin
            if (pix_we) shadow[int'(pix_addr)] = pix_wdata;
            else pix_q.push_back('{data: shadow_rd(pix_addr), due: cyc + 2});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        core_req = 0; core_we = 0; core_lock = 0; core_addr = 0; core_wdata = 0;
        pix_req  = 0; pix_we  = 0; pix_lock  = 0; pix_addr  = 0; pix_wdata  = 0;
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 20 && (core_q.size() != 0 || pix_q.size() != 0); k++) tick();
        tests++;
        if (core_q.size() != 0 || pix_q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: core_q=%0d pix_q=%0d outstanding, required 0",
                     core_q.size(), pix_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 0;
        idle_all();
        core_req = 1; core_addr = 16'h0011;
        pix_req  = 1; pix_addr  = 16'h0022;
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (core_gnt !== 1'b0 || pix_gnt !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 16'h0
                || core_rvalid !== 1'b0 || pix_rvalid !== 1'b0) begin
                fails++;
                $display("FAIL reset_state: gnt %b%b we %b addr %h rvalid %b%b, required all zero",
                         core_gnt, pix_gnt, ram_we, ram_addr, core_rvalid, pix_rvalid);
            end
            tick();
        end
    endtask

    task automatic test_tie_alternation();
        logic exp_core;
        idle_all();
        rst = 1;
        core_req = 1; core_addr = 16'h0010;
        pix_req  = 1; pix_addr  = 16'h0020;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp_core = (i % 2 == 0);
            tests++;
            if (core_gnt !== exp_core || pix_gnt !== !exp_core) begin
                fails++;
                $display("FAIL tie_order[%0d]: gnt core/pix %b/%b, required %b/%b",
                         i, core_gnt, pix_gnt, exp_core, !exp_core);
            end
            if (i > 0) begin
                tests++;
                if (ram_addr !== (exp_core ? 16'h0020 : 16'h0010) || ram_we !== 1'b0) begin
                    fails++;
                    $display("FAIL tie_ram_addr[%0d]: addr %h we %b, required %h we 0",
                             i, ram_addr, ram_we, exp_core ? 16'h0020 : 16'h0010);
                end
            end
            tick();
        end
        idle_all();
        drain();
    endtask

    task automatic test_lock();
        bit seen;
        idle_all();
        core_req = 1; core_lock = 1; core_addr = 16'h0100;
        pix_req  = 1; pix_addr  = 16'h0030;
        @(negedge clk);
        tests++;
        if (core_gnt !== 1'b1 || pix_gnt !== 1'b0) begin
            fails++;
            $display("FAIL lock_first: gnt core/pix %b/%b, required 1/0", core_gnt, pix_gnt);
        end
        tick();
        core_we = 1; core_lock = 0; core_wdata = 16'hBEEF;
        @(negedge clk);
        tests++;
        if (core_gnt !== 1'b1 || pix_gnt !== 1'b0) begin
            fails++;
            $display("FAIL lock_held: gnt core/pix %b/%b, required 1/0", core_gnt, pix_gnt);
        end
        tick();
        core_req = 0; core_we = 0;
        @(negedge clk);
        tests++;
        if (pix_gnt !== 1'b1 || core_gnt !== 1'b0) begin
            fails++;
            $display("FAIL lock_release: gnt core/pix %b/%b, required 0/1", core_gnt, pix_gnt);
        end
        tick();
        pix_req = 0;
        core_req = 1; core_addr = 16'h0100;
        @(negedge clk);
        tick();
        core_req = 0;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (core_rvalid) begin
                seen = 1;
                tests++;
                if (core_rdata !== 16'hBEEF) begin
                    fails++;
                    $display("FAIL lock_rmw_readback: got %h, required beef", core_rdata);
                end
            end
            tick();
        end
        if (!seen) begin
            tests++; fails++;
            $display("FAIL lock_rmw_timeout: no core_rvalid within 10 cycles");
        end
        drain();
    endtask

    task automatic test_lock_cap();
        logic [6:0] pattern;
        pattern = 7'b1101111;
        idle_all();
        core_req = 1; core_lock = 1; core_addr = 16'h0040;
        pix_addr = 16'h0050;
        for (int i = 0; i < 7; i++) begin
            if (i == 1) pix_req = 1;
            if (i == 6) core_lock = 0;
            @(negedge clk);
            tests++;
            if (core_gnt !== pattern[i] || pix_gnt !== !pattern[i]) begin
                fails++;
                $display("FAIL lock_cap[%0d]: gnt core/pix %b/%b, required %b/%b",
                         i, core_gnt, pix_gnt, pattern[i], !pattern[i]);
            end
            tick();
        end
        idle_all();
        drain();
    endtask

    task automatic test_reset_mid_read();
        idle_all();
        pix_req = 1; pix_addr = 16'h0060;
        @(negedge clk);
        tests++;
        if (pix_gnt !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_grant: pix_gnt %b, required 1", pix_gnt);
        end
        tick();
        pix_req = 0;
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (pix_rvalid !== 1'b0 || pix_gnt !== 1'b0) begin
                fails++;
                $display("FAIL rstmid_quiet[%0d]: pix_rvalid %b pix_gnt %b, required 0 0",
                         i, pix_rvalid, pix_gnt);
            end
            tick();
        end
        rst = 1;
        tests++;
        if (pix_q.size() != 1) begin
            fails++;
            $display("FAIL rstmid_dropped: pix reads outstanding %0d, required 1 (never returned)",
                     pix_q.size());
        end
        pix_q.delete();
        @(negedge clk);
        tests++;
        if (pix_rdata !== 16'h0 || ram_we !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_rdata: pix_rdata %h ram_we %b, required 0000 0", pix_rdata, ram_we);
        end
        tick();
    endtask

    task automatic test_idle_hold();
        bit seen;
        idle_all();
        core_req = 1; core_we = 1; core_addr = 16'h0070; core_wdata = 16'h1234;
        @(negedge clk);
        tests++;
        if (core_gnt !== 1'b1) begin
            fails++;
            $display("FAIL idle_write_gnt: core_gnt %b, required 1", core_gnt);
        end
        tick();
        idle_all();
        @(negedge clk);
        tests++;
        if (ram_we !== 1'b1 || ram_addr !== 16'h0070 || ram_wdata !== 16'h1234) begin
            fails++;
            $display("FAIL idle_write_reg: we %b addr %h wdata %h, required 1 0070 1234",
                     ram_we, ram_addr, ram_wdata);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (ram_we !== 1'b0 || ram_addr !== 16'h0070) begin
                fails++;
                $display("FAIL idle_hold[%0d]: we %b addr %h, required 0 0070", i, ram_we, ram_addr);
            end
            tick();
        end
        pix_req = 1; pix_addr = 16'h0070;
        @(negedge clk);
        tick();
        pix_req = 0;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (pix_rvalid) begin
                seen = 1;
                tests++;
                if (pix_rdata !== 16'h1234) begin
                    fails++;
                    $display("FAIL idle_readback: got %h, required 1234", pix_rdata);
                end
            end
            tick();
        end
        if (!seen) begin
            tests++; fails++;
            $display("FAIL idle_readback_timeout: no pix_rvalid within 10 cycles");
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_tie_alternation();
        test_lock();
        test_lock_cap();
        test_reset_mid_read();
        test_idle_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
